prt_dp_pm_mutex_client: RTL and testbench

//  Local-bus initiator that acquires and releases one bit of the PM mutex peripheral on behalf of a hardware agent.
//  - It drives the mutex's local bus: set register at 1, clear register at 2, read of any address returns mutex bits.
//  - It retries with backoff until the mutex read-back shows it is sole owner.
//  - It sits between a hardware engine (e.g. a link-training sequencer) and the PM local-bus fabric.

---
 rtl/prt_dp_pm_pkg.sv | 29 ++
 rtl/prt_dp_lb_if.sv | 16 +
 rtl/prt_dp_pm_cnt.sv | 31 +++
 rtl/prt_dp_pm_mutex_client.sv | 187 ++++++++++++++++++
 tb/tb_prt_dp_pm_mutex_client.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prt_dp_pm_pkg.sv
// Shared definitions for the PM local-bus blocks: bus widths, mutex
// register map and the mutex client state encoding.
package prt_dp_pm_pkg;

    localparam int P_LB_ADR_W    = 8;
    localparam int P_LB_DAT_W    = 32;
    localparam int P_MUTEX_WIDTH = 4;

    localparam logic [P_LB_ADR_W-1:0] P_MUTEX_ADR_CTL = 8'd0;
    localparam logic [P_LB_ADR_W-1:0] P_MUTEX_ADR_SET = 8'd1;
    localparam logic [P_LB_ADR_W-1:0] P_MUTEX_ADR_CLR = 8'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET,
        ST_RD,
        ST_WAIT,
        ST_BACKOFF,
        ST_OWN,
        ST_CLR,
        ST_ERR
    } mutex_state_t;

    // One-hot pattern of the mutex bit owned by client id.
    function automatic logic [P_MUTEX_WIDTH-1:0] mutex_mask(input int id);
        return P_MUTEX_WIDTH'(1) << id;
    endfunction

endpackage

// File: rtl/prt_dp_lb_if.sv
// PM local bus: the initiator drives address, strobes and write data;
// the responder returns read data qualified by vld.
interface prt_dp_lb_if;
    import prt_dp_pm_pkg::*;

    logic [P_LB_ADR_W-1:0] adr;
    logic                  wr;
    logic                  rd;
    logic [P_LB_DAT_W-1:0] din;
    logic [P_LB_DAT_W-1:0] dout;
    logic                  vld;

    modport lb_out (output adr, wr, rd, din, input dout, vld);
    modport lb_in  (input adr, wr, rd, din, output dout, vld);

endinterface

// File: rtl/prt_dp_pm_cnt.sv
// Saturating down-counter: load to P_MAX, count down while enabled,
// stop at zero. Used for the backoff and read-timeout windows.
module prt_dp_pm_cnt #(
    parameter int P_MAX = 1
) (
    input  logic CLK_IN,
    input  logic RST_IN,
    input  logic i_load,
    input  logic i_en,
    output logic o_zero
);

    localparam int LP_W = (P_MAX < 1) ? 1 : $clog2(P_MAX + 1);

    logic [LP_W-1:0] r_cnt;

    // Load has priority over counting; counting holds at zero.
    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LP_W'(P_MAX);
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - LP_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/prt_dp_pm_mutex_client.sv
// PM mutex client: acquires bit P_ID of the mutex peripheral over the
// local bus (set, read back, back off on contention) and releases it with
// a clear write when the agent is done.
module prt_dp_pm_mutex_client
    import prt_dp_pm_pkg::*;
#(
    parameter int P_ID      = 0,
    parameter int P_BACKOFF = 16,
    parameter int P_TIMEOUT = 8,
    parameter int P_RETRY   = 255
) (
    input  logic             CLK_IN,
    input  logic             RST_IN,
    prt_dp_lb_if.lb_out      LB_IF,
    input  logic             ACQ_IN,
    input  logic             REL_IN,
    output logic             GNT_OUT,
    output logic             BUSY_OUT,
    output logic             ERR_OUT
);

    localparam logic [P_MUTEX_WIDTH-1:0] LP_MASK    = mutex_mask(P_ID);
    localparam logic [P_LB_DAT_W-1:0]    LP_WR_DATA = P_LB_DAT_W'(LP_MASK);
    localparam logic [7:0]               LP_RETRY   = 8'(P_RETRY);

    mutex_state_t          r_state;
    mutex_state_t          w_next;
    logic [P_LB_ADR_W-1:0] r_adr;
    logic [P_LB_ADR_W-1:0] w_adr;
    logic [P_LB_DAT_W-1:0] r_din;
    logic [P_LB_DAT_W-1:0] w_din;
    logic [7:0]            r_retry;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_owner;
    logic                  w_retry_hit;
    logic                  w_retry_clr;
    logic                  w_retry_inc;
    logic                  w_to_load;
    logic                  w_to_en;
    logic                  w_to_zero;
    logic                  w_bo_load;
    logic                  w_bo_en;
    logic                  w_bo_zero;
    logic                  w_unused_dout;

    // Sole owner only when no other mutex bit is set alongside ours.
    assign w_owner       = (LB_IF.dout[P_MUTEX_WIDTH-1:0] == LP_MASK);
    assign w_unused_dout = ^LB_IF.dout[P_LB_DAT_W-1:P_MUTEX_WIDTH];
    assign w_retry_hit   = (P_RETRY != 0) && (r_retry == LP_RETRY);

    // Read window: P_TIMEOUT cycles in WAIT after the rd strobe.
    prt_dp_pm_cnt #(.P_MAX(P_TIMEOUT - 1)) u_timeout (
        .CLK_IN (CLK_IN),
        .RST_IN (RST_IN),
        .i_load (w_to_load),
        .i_en   (w_to_en),
        .o_zero (w_to_zero)
    );

    // Backoff window: P_BACKOFF cycles spent in BACKOFF before retrying.
    prt_dp_pm_cnt #(.P_MAX(P_BACKOFF - 1)) u_backoff (
        .CLK_IN (CLK_IN),
        .RST_IN (RST_IN),
        .i_load (w_bo_load),
        .i_en   (w_bo_en),
        .o_zero (w_bo_zero)
    );

    // Next-state, bus strobes and status outputs.
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        w_next      = r_state;
        w_wr        = 1'b0;
        w_rd        = 1'b0;
        w_adr       = r_adr;
        w_din       = r_din;
        w_to_load   = 1'b0;
        w_to_en     = 1'b0;
        w_bo_load   = 1'b0;
        w_bo_en     = 1'b0;
        w_retry_clr = 1'b0;
        w_retry_inc = 1'b0;
        GNT_OUT     = 1'b0;
        BUSY_OUT    = 1'b1;
        ERR_OUT     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                BUSY_OUT = 1'b0;
                if (ACQ_IN) begin
                    w_next      = ST_SET;
                    w_retry_clr = 1'b1;
                end
            end
            ST_SET: begin
                w_wr   = 1'b1;
                w_adr  = P_MUTEX_ADR_SET;
                w_din  = LP_WR_DATA;
                w_next = ST_RD;
            end
            ST_RD: begin
                w_rd      = 1'b1;
                w_adr     = P_MUTEX_ADR_SET;
                w_to_load = 1'b1;
                w_next    = ST_WAIT;
            end
            ST_WAIT: begin
                if (LB_IF.vld) begin
                    if (w_owner) begin
                        // Agent gave up mid-attempt: hand the bit straight back.
                        w_next = ACQ_IN ? ST_OWN : ST_CLR;
                    end else begin
                        w_next      = ST_BACKOFF;
                        w_retry_inc = 1'b1;
                        w_bo_load   = 1'b1;
                    end
                end else if (w_to_zero) begin
                    w_next = ST_ERR;
                end else begin
                    w_to_en = 1'b1;
                end
            end
            ST_BACKOFF: begin
                if (w_retry_hit) begin
                    w_next = ST_ERR;
                end else if (w_bo_zero) begin
                    // No point retrying once the agent has withdrawn its request.
                    w_next = ACQ_IN ? ST_SET : ST_IDLE;
                end else begin
                    w_bo_en = 1'b1;
                end
            end
            ST_OWN: begin
                BUSY_OUT = 1'b0;
                GNT_OUT  = 1'b1;
                if (REL_IN) begin
                    w_next = ST_CLR;
                end
            end
            ST_CLR: begin
                w_wr   = 1'b1;
                w_adr  = P_MUTEX_ADR_CLR;
                w_din  = LP_WR_DATA;
                w_next = ST_IDLE;
            end
            ST_ERR: begin
                ERR_OUT = 1'b1;
                if (!ACQ_IN) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register; address and write data are held between strobes.
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            r_state <= ST_IDLE;
            r_adr   <= '0;
            r_din   <= '0;
        end else begin
            r_state <= w_next;
            r_adr   <= w_adr;
            r_din   <= w_din;
        end
    end

    // Failed-attempt counter for the current acquire, saturating at 255.
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            r_retry <= '0;
        end else if (w_retry_clr) begin
            r_retry <= '0;
        end else if (w_retry_inc && (r_retry != 8'hFF)) begin
            r_retry <= r_retry + 8'd1;
        end
    end

    assign LB_IF.adr = w_adr;
    assign LB_IF.din = w_din;
    assign LB_IF.wr  = w_wr;
    assign LB_IF.rd  = w_rd;

endmodule

// File: tb/tb_prt_dp_pm_mutex_client.sv
// Bench for the PM mutex client. Two clients share clock and reset:
// dut0 (bit 0, unlimited-ish retries) and dut1 (bit 2, retry limit 2).
// Expected bus/status events are queued by the stimulus; a monitor pops
// and compares each event the DUTs present, including cycle spacing.
module tb_prt_dp_pm_mutex_client;
    import prt_dp_pm_pkg::*;

    typedef enum logic [2:0] {EV_WR, EV_RD, EV_GNT, EV_GNTF, EV_ERR, EV_ERRF} ev_e;
    typedef struct {
        ev_e         kind;
        logic [7:0]  adr;
        logic [31:0] din;
        int          dly;   // cycles since previous event of that DUT, -1 = any
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  acq = '0;
    logic [1:0]  rel = '0;
    logic [1:0]  t_vld;
    logic [31:0] t_dout [2];
    logic [31:0] resp_def [2];
    logic [1:0]  resp_en = 2'b11;
    logic [1:0]  stray = '0;
    logic [31:0] resp_q0 [$];
    logic [31:0] resp_q1 [$];
    exp_t        exp_q0 [$];
    exp_t        exp_q1 [$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_cyc [2];

    always #5 clk = ~clk;

    prt_dp_lb_if lb0 ();
    prt_dp_lb_if lb1 ();

    wire [1:0]  m_gnt;
    wire [1:0]  m_busy;
    wire [1:0]  m_err;
    wire [1:0]  m_wr = {lb1.wr, lb0.wr};
    wire [1:0]  m_rd = {lb1.rd, lb0.rd};
    wire [7:0]  m_adr [2];
    wire [31:0] m_din [2];
    assign m_adr[0] = lb0.adr;
    assign m_adr[1] = lb1.adr;
    assign m_din[0] = lb0.din;
    assign m_din[1] = lb1.din;
    assign lb0.vld  = t_vld[0];
    assign lb1.vld  = t_vld[1];
    assign lb0.dout = t_dout[0];
    assign lb1.dout = t_dout[1];

    prt_dp_pm_mutex_client #(.P_ID(0), .P_BACKOFF(16), .P_TIMEOUT(8), .P_RETRY(255)) dut0 (
        .CLK_IN(clk), .RST_IN(rst), .LB_IF(lb0.lb_out), .ACQ_IN(acq[0]), .REL_IN(rel[0]),
        .GNT_OUT(m_gnt[0]), .BUSY_OUT(m_busy[0]), .ERR_OUT(m_err[0]));

    prt_dp_pm_mutex_client #(.P_ID(2), .P_BACKOFF(16), .P_TIMEOUT(8), .P_RETRY(2)) dut1 (
        .CLK_IN(clk), .RST_IN(rst), .LB_IF(lb1.lb_out), .ACQ_IN(acq[1]), .REL_IN(rel[1]),
        .GNT_OUT(m_gnt[1]), .BUSY_OUT(m_busy[1]), .ERR_OUT(m_err[1]));

    function automatic logic [31:0] next_resp(int d);
        if (d == 0 && resp_q0.size() != 0) return resp_q0.pop_front();
        if (d == 1 && resp_q1.size() != 0) return resp_q1.pop_front();
        return resp_def[d];
    endfunction

    // Responder model: registers rd, answers with vld one cycle later.
    initial begin
        logic [1:0] pend;
        t_vld = '0;
        t_dout[0] = '0;
        t_dout[1] = '0;
        forever begin
            @(negedge clk);
            pend = m_rd;
            @(posedge clk);
            #1;
            t_vld = '0;
            for (int d = 0; d < 2; d++) begin
                if (pend[d] && resp_en[d]) begin
                    t_vld[d]  = 1'b1;
                    t_dout[d] = next_resp(d);
                end else if (stray[d]) begin
                    t_vld[d]  = 1'b1;
                    t_dout[d] = 32'h1 << (2 * d);
                    stray[d]  = 1'b0;
                end
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_quiet(int d, string tag);
        check({tag, "_wr"},   32'(m_wr[d]),   32'h0);
        check({tag, "_rd"},   32'(m_rd[d]),   32'h0);
        check({tag, "_adr"},  32'(m_adr[d]),  32'h0);
        check({tag, "_din"},  m_din[d],       32'h0);
        check({tag, "_gnt"},  32'(m_gnt[d]),  32'h0);
        check({tag, "_busy"}, 32'(m_busy[d]), 32'h0);
        check({tag, "_err"},  32'(m_err[d]),  32'h0);
    endtask

    task automatic observe(int d, ev_e k, logic [7:0] adr, logic [31:0] din);
        exp_t e;
        int   dly;
        logic bad;
        dly = cyc - last_cyc[d];
        last_cyc[d] = cyc;
        n_tests++;
        if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
            n_fail++;
            $display("FAIL ev_d%0d: got unexpected %s adr=%0h din=%0h, expected no event",
                     d, k.name(), adr, din);
            return;
        end
        if (d == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        bad = (k != e.kind) || (e.dly >= 0 && dly != e.dly);
        if (k == EV_WR || k == EV_RD) bad = bad || (adr != e.adr) || (din != e.din);
        if (bad) begin
            n_fail++;
            $display("FAIL ev_d%0d: got %s adr=%0h din=%0h dly=%0d, expected %s adr=%0h din=%0h dly=%0d",
                     d, k.name(), adr, din, dly, e.kind.name(), e.adr, e.din, e.dly);
        end
    endtask

    // Monitor: turns strobes and status edges into events.
    initial begin
        logic [1:0] pg;
        logic [1:0] pe;
        pg = '0;
        pe = '0;
        last_cyc[0] = 0;
        last_cyc[1] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pg = '0;
                pe = '0;
            end else begin
                for (int d = 0; d < 2; d++) begin
                    if (m_wr[d])               observe(d, EV_WR, m_adr[d], m_din[d]);
                    if (m_rd[d])               observe(d, EV_RD, m_adr[d], m_din[d]);
                    if (m_gnt[d] && !pg[d])    observe(d, EV_GNT, '0, '0);
                    if (!m_gnt[d] && pg[d])    observe(d, EV_GNTF, '0, '0);
                    if (m_err[d] && !pe[d])    observe(d, EV_ERR, '0, '0);
                    if (!m_err[d] && pe[d])    observe(d, EV_ERRF, '0, '0);
                    pg[d] = m_gnt[d];
                    pe[d] = m_err[d];
                end
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ex(int d, ev_e k, logic [7:0] adr, logic [31:0] din, int dly);
        exp_t e;
        e.kind = k;
        e.adr  = adr;
        e.din  = din;
        e.dly  = dly;
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    function automatic int pending(int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    // Wait (bounded) until the monitor has consumed every expected event.
    task automatic drain(int d, int budget, string name);
        int k = 0;
        while (pending(d) != 0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (pending(d) != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_%s: got %0d events still pending, expected 0", name, pending(d));
            if (d == 0) exp_q0.delete();
            else        exp_q1.delete();
        end
    endtask

    task automatic release0(string name);
        ex(0, EV_WR, P_MUTEX_ADR_CLR, 32'h1, -1);
        ex(0, EV_GNTF, '0, '0, 0);
        acq[0] = 1'b0;
        rel[0] = 1'b1;
        step(1);
        rel[0] = 1'b0;
        drain(0, 20, name);
        step(2);
    endtask

    task automatic acquire0(string name);
        ex(0, EV_WR, P_MUTEX_ADR_SET, 32'h1, -1);
        ex(0, EV_RD, P_MUTEX_ADR_SET, 32'h1, 1);
        ex(0, EV_GNT, '0, '0, 2);
        acq[0] = 1'b1;
        drain(0, 20, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resp_def[0] = 32'h1;
        resp_def[1] = 32'h4;
        #2;
        check_quiet(0, "reset0");
        check_quiet(1, "reset1");
        step(2);
        rst = 1'b0;
        step(2);

        // Uncontended acquire: SET, RD, WAIT, then GNT.
        acquire0("uncontended");
        check("own_gnt", 32'(m_gnt[0]), 32'h1);
        check("own_busy", 32'(m_busy[0]), 32'h0);

        // Release with ACQ still high: clear, one IDLE cycle, restart at SET.
        step(1);
        ex(0, EV_WR, P_MUTEX_ADR_CLR, 32'h1, -1);
        ex(0, EV_GNTF, '0, '0, 0);
        ex(0, EV_WR, P_MUTEX_ADR_SET, 32'h1, 2);
        ex(0, EV_RD, P_MUTEX_ADR_SET, 32'h1, 1);
        ex(0, EV_GNT, '0, '0, 2);
        rel[0] = 1'b1;
        step(1);
        rel[0] = 1'b0;
        drain(0, 30, "release_reacquire");

        // ACQ low alone does not give up ownership; REL does.
        acq[0] = 1'b0;
        step(3);
        check("own_hold_gnt", 32'(m_gnt[0]), 32'h1);
        release0("release");
        check("idle_busy", 32'(m_busy[0]), 32'h0);

        // REL and a stray vld outside OWN/WAIT are ignored.
        stray[0] = 1'b1;
        rel[0] = 1'b1;
        step(1);
        rel[0] = 1'b0;
        step(4);
        check("stray_gnt", 32'(m_gnt[0]), 32'h0);
        check("stray_busy", 32'(m_busy[0]), 32'h0);

        // ACQ dropped mid-acquire: attempt completes, clear follows at once.
        ex(0, EV_WR, P_MUTEX_ADR_SET, 32'h1, -1);
        ex(0, EV_RD, P_MUTEX_ADR_SET, 32'h1, 1);
        ex(0, EV_WR, P_MUTEX_ADR_CLR, 32'h1, 2);
        acq[0] = 1'b1;
        step(1);
        acq[0] = 1'b0;
        drain(0, 20, "drop_mid");
        step(2);
        check("drop_busy", 32'(m_busy[0]), 32'h0);

        // Contended: three busy read-backs, 16-cycle backoffs, then ownership.
        resp_q0.push_back(32'h4);
        resp_q0.push_back(32'h4);
        resp_q0.push_back(32'h4);
        resp_q0.push_back(32'h1);
        ex(0, EV_WR, P_MUTEX_ADR_SET, 32'h1, -1);
        ex(0, EV_RD, P_MUTEX_ADR_SET, 32'h1, 1);
        for (int i = 0; i < 3; i++) begin
            ex(0, EV_WR, P_MUTEX_ADR_SET, 32'h1, 18);
            ex(0, EV_RD, P_MUTEX_ADR_SET, 32'h1, 1);
        end
        ex(0, EV_GNT, '0, '0, 2);
        acq[0] = 1'b1;
        drain(0, 200, "contended");
        release0("contended_release");

        // Timeout: no vld ever; ERR after the 8-cycle read window.
        resp_en[0] = 1'b0;
        ex(0, EV_WR, P_MUTEX_ADR_SET, 32'h1, -1);
        ex(0, EV_RD, P_MUTEX_ADR_SET, 32'h1, 1);
        ex(0, EV_ERR, '0, '0, 9);
        acq[0] = 1'b1;
        drain(0, 40, "timeout");
        step(5);
        check("timeout_err_held", 32'(m_err[0]), 32'h1);
        check("timeout_busy", 32'(m_busy[0]), 32'h1);
        ex(0, EV_ERRF, '0, '0, -1);
        acq[0] = 1'b0;
        drain(0, 5, "timeout_clear");
        check("timeout_err_clr", 32'(m_err[0]), 32'h0);
        resp_en[0] = 1'b1;
        step(2);

        // Retry limit 2 on dut1: peripheral reads 0, then another owner.
        resp_q1.push_back(32'h0);
        resp_q1.push_back(32'h1);
        ex(1, EV_WR, P_MUTEX_ADR_SET, 32'h4, -1);
        ex(1, EV_RD, P_MUTEX_ADR_SET, 32'h4, 1);
        ex(1, EV_WR, P_MUTEX_ADR_SET, 32'h4, 18);
        ex(1, EV_RD, P_MUTEX_ADR_SET, 32'h4, 1);
        ex(1, EV_ERR, '0, '0, 3);
        acq[1] = 1'b1;
        drain(1, 100, "retry_limit");
        step(20);
        check("retry_err_held", 32'(m_err[1]), 32'h1);
        check("retry_gnt", 32'(m_gnt[1]), 32'h0);
        ex(1, EV_ERRF, '0, '0, -1);
        acq[1] = 1'b0;
        drain(1, 5, "retry_clear");
        check("retry_err_clr", 32'(m_err[1]), 32'h0);

        // Reset in WAIT: outputs drop asynchronously, next acquire is clean.
        resp_en[0] = 1'b0;
        ex(0, EV_WR, P_MUTEX_ADR_SET, 32'h1, -1);
        ex(0, EV_RD, P_MUTEX_ADR_SET, 32'h1, 1);
        acq[0] = 1'b1;
        drain(0, 20, "pre_rst_wait");
        step(1);
        check("wait_busy", 32'(m_busy[0]), 32'h1);
        rst = 1'b1;
        #1;
        check_quiet(0, "rst_wait");
        acq[0] = 1'b0;
        resp_en[0] = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
        acquire0("post_rst_wait");
        release0("post_rst_wait_rel");

        // Reset in BACKOFF.
        resp_q0.push_back(32'h4);
        ex(0, EV_WR, P_MUTEX_ADR_SET, 32'h1, -1);
        ex(0, EV_RD, P_MUTEX_ADR_SET, 32'h1, 1);
        acq[0] = 1'b1;
        drain(0, 20, "pre_rst_backoff");
        step(3);
        check("backoff_busy", 32'(m_busy[0]), 32'h1);
        rst = 1'b1;
        #1;
        check_quiet(0, "rst_backoff");
        acq[0] = 1'b0;
        step(2);
        rst = 1'b0;
        step(2);
        acquire0("post_rst_backoff");
        release0("post_rst_backoff_rel");

        step(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
